// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus_timer device: register offsets, field indices,
// reset constants and the decoded register enum.
package bus_timer_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_PRESCALE = 8'h04;
    localparam logic [7:0] OFF_MTIME_LO = 8'h08;
    localparam logic [7:0] OFF_MTIME_HI = 8'h0C;
    localparam logic [7:0] OFF_CMP_LO   = 8'h10;
    localparam logic [7:0] OFF_CMP_HI   = 8'h14;
    localparam logic [7:0] OFF_STATUS   = 8'h18;
    localparam logic [7:0] OFF_UNMAPPED = 8'h1C;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_IRQ_EN_BIT  = 1;
    localparam int STATUS_MATCH_BIT = 0;

    localparam logic [1:0]  CTRL_RESET   = 2'b00;
    localparam logic [63:0] MTIME_RESET  = 64'h0000_0000_0000_0000;
    localparam logic [63:0] CMP_RESET    = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] SHADOW_RESET = 32'h0000_0000;
    localparam logic        MATCH_RESET  = 1'b0;

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_MTIME_LO = 3'd2,
        REG_MTIME_HI = 3'd3,
        REG_CMP_LO   = 3'd4,
        REG_CMP_HI   = 3'd5,
        REG_STATUS   = 3'd6,
        REG_UNMAPPED = 3'd7
    } timer_reg_e;

endpackage

// File: rtl/bus_timer_prescaler.sv
// Prescaler for bus_timer: emits one tick every PRESCALE+1 enabled cycles.
module bus_timer_prescaler
    import bus_timer_pkg::*;
#(
    parameter int PrescaleWidth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     clear_i,
    input  logic [PrescaleWidth-1:0] prescale_i,
    output logic                     tick_o
);

    logic [PrescaleWidth-1:0] pcnt_r;

    assign tick_o = en_i & (pcnt_r == prescale_i);

    // Cycle counter: restarts on a PRESCALE write or a tick, holds while disabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pcnt_r <= {PrescaleWidth{1'b0}};
        end else if (clear_i) begin
            pcnt_r <= {PrescaleWidth{1'b0}};
        end else if (tick_o) begin
            pcnt_r <= {PrescaleWidth{1'b0}};
        end else if (en_i) begin
            pcnt_r <= pcnt_r + {{(PrescaleWidth-1){1'b0}}, 1'b1};
        end else begin
            pcnt_r <= pcnt_r;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 64-bit timer: prescaled MTIME, 64-bit compare, sticky MATCH
// flag and level interrupt, with single-cycle registered reads.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int PrescaleWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [AddressWidth-1:0] addr_i,
    input  logic [DataWidth-1:0]    wdata_i,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    irq_o
);

    if (DataWidth != 32) begin : g_data_width_check
        $error("bus_timer: DataWidth must be 32");
    end

    timer_reg_e               reg_sel_s;
    logic                     wr_s;
    logic                     rd_s;
    logic                     tick_s;
    logic                     prescale_wr_s;
    logic [1:0]               ctrl_r;
    logic [1:0]               ctrl_next_s;
    logic [PrescaleWidth-1:0] prescale_r;
    logic [63:0]              mtime_r;
    logic [63:0]              cmp_r;
    logic [31:0]              shadow_hi_r;
    logic [DataWidth-1:0]     rdata_r;
    logic [DataWidth-1:0]     rdata_next_s;
    logic                     match_r;
    logic                     match_next_s;
    logic                     irq_r;
    logic                     unused_addr_s;

    assign reg_sel_s     = timer_reg_e'(addr_i[4:2]);
    assign wr_s          = req_i & we_i;
    assign rd_s          = req_i & ~we_i;
    assign prescale_wr_s = wr_s & (reg_sel_s == REG_PRESCALE);
    assign unused_addr_s = ^{addr_i[AddressWidth-1:5], addr_i[1:0]};

    bus_timer_prescaler #(
        .PrescaleWidth(PrescaleWidth)
    ) u_prescaler (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (ctrl_r[CTRL_EN_BIT]),
        .clear_i   (prescale_wr_s),
        .prescale_i(prescale_r),
        .tick_o    (tick_s)
    );

    // Next CTRL and MATCH values; a true compare beats a same-cycle W1C.
    always_comb begin
        ctrl_next_s  = ctrl_r;
        match_next_s = match_r;
        if (wr_s && (reg_sel_s == REG_CTRL)) begin
            ctrl_next_s = wdata_i[1:0];
        end else begin
            ctrl_next_s = ctrl_r;
        end
        if (mtime_r >= cmp_r) begin
            match_next_s = 1'b1;
        end else if (wr_s && (reg_sel_s == REG_STATUS) && wdata_i[STATUS_MATCH_BIT]) begin
            match_next_s = 1'b0;
        end else begin
            match_next_s = match_r;
        end
    end

    // Read mux; MTIME_HI returns the half captured by the last MTIME_LO read.
    always_comb begin
        rdata_next_s = {DataWidth{1'b0}};
        if (rd_s) begin
            case (reg_sel_s)
                REG_CTRL:     rdata_next_s = {{(DataWidth-2){1'b0}}, ctrl_r};
                REG_PRESCALE: rdata_next_s = DataWidth'(prescale_r);
                REG_MTIME_LO: rdata_next_s = mtime_r[31:0];
                REG_MTIME_HI: rdata_next_s = shadow_hi_r;
                REG_CMP_LO:   rdata_next_s = cmp_r[31:0];
                REG_CMP_HI:   rdata_next_s = cmp_r[63:32];
                REG_STATUS:   rdata_next_s = {{(DataWidth-1){1'b0}}, match_r};
                default:      rdata_next_s = {DataWidth{1'b0}};
            endcase
        end else begin
            rdata_next_s = {DataWidth{1'b0}};
        end
    end

    // Register file, counter, shadow, flags and registered bus outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_r      <= CTRL_RESET;
            prescale_r  <= {PrescaleWidth{1'b0}};
            mtime_r     <= MTIME_RESET;
            cmp_r       <= CMP_RESET;
            shadow_hi_r <= SHADOW_RESET;
            match_r     <= MATCH_RESET;
            irq_r       <= 1'b0;
            rdata_r     <= {DataWidth{1'b0}};
        end else begin
            ctrl_r  <= ctrl_next_s;
            match_r <= match_next_s;
            irq_r   <= match_next_s & ctrl_next_s[CTRL_IRQ_EN_BIT];
            rdata_r <= rdata_next_s;
            if (prescale_wr_s) begin
                prescale_r <= wdata_i[PrescaleWidth-1:0];
            end
            if (wr_s && (reg_sel_s == REG_CMP_LO)) begin
                cmp_r[31:0] <= wdata_i;
            end else if (wr_s && (reg_sel_s == REG_CMP_HI)) begin
                cmp_r[63:32] <= wdata_i;
            end
            // A software write to either half swallows a coincident tick.
            if (wr_s && (reg_sel_s == REG_MTIME_LO)) begin
                mtime_r[31:0] <= wdata_i;
            end else if (wr_s && (reg_sel_s == REG_MTIME_HI)) begin
                mtime_r[63:32] <= wdata_i;
            end else if (tick_s) begin
                mtime_r <= mtime_r + 64'd1;
            end
            if (rd_s && (reg_sel_s == REG_MTIME_LO)) begin
                shadow_hi_r <= mtime_r[63:32];
            end
        end
    end

    assign rdata_o = rdata_r;
    assign irq_o   = irq_r;

endmodule

// File: doc/bus_timer.md
# bus_timer

- Memory-mapped 64-bit timer device. It is a slave attached to one `device_*` port of the shared bus interconnect.
- It consumes the interconnect's request, write-enable, address and write-data outputs. It returns registered read data one cycle after a read, which matches the interconnect's registered response select.
- It provides a prescaled free-running counter, a 64-bit compare register, a sticky match flag and a level interrupt for the host CPU.

## Interface
Parameters:
- `DataWidth`, 32, bus data width; fixed at 32, elaborate-time error otherwise.
- `AddressWidth`, 32, bus address width.
- `PrescaleWidth`, 16, width of prescaler counter and PRESCALE register.

Ports:
- `clk_i` input 1: single clock.
- `rst_ni` input 1: asynchronous, active-low reset.
- `req_i` input 1: access request from interconnect `device_req_o`.
- `we_i` input 1: 1 = write, 0 = read.
- `addr_i` input AddressWidth: byte address; only `addr_i[4:2]` decoded.
- `wdata_i` input DataWidth: write data; full-word writes only.
- `rdata_o` output DataWidth: registered read data, to interconnect `device_rdata_i`.
- `irq_o` output 1: timer interrupt, level, active-high.

## Operation
Register map (offsets from `addr_i[4:2]`, reset values in brackets):
- 0x00 CTRL: bit0 EN, bit1 IRQ_EN; other bits read 0. [0]
- 0x04 PRESCALE: ticks occur every PRESCALE+1 cycles. [0]
- 0x08 MTIME_LO [0]
- 0x0C MTIME_HI: reads return SHADOW_HI. [0]
- 0x10 CMP_LO [0xFFFF_FFFF]
- 0x14 CMP_HI [0xFFFF_FFFF]
- 0x18 STATUS: bit0 MATCH, sticky, write-1-to-clear. [0]
- 0x1C: unmapped; reads 0, writes ignored.

Prescaler:
- When EN=1, `pcnt` increments each cycle.
- When `pcnt == PRESCALE`, a tick is asserted and `pcnt` becomes 0.
- When EN=0, `pcnt` holds and there are no ticks.
- Any PRESCALE write clears `pcnt` to 0.

Counter:
- A tick increments the 64-bit MTIME with carry from LO into HI.
- 0xFFFF_FFFF_FFFF_FFFF wraps to 0; MATCH is unaffected by the wrap itself.
- A software write to MTIME_LO or MTIME_HI in the same cycle as a tick wins. The written half takes `wdata_i`, the other half holds, and that tick is lost.

Atomic read:
- A read of MTIME_LO captures the current MTIME_HI into SHADOW_HI.
- A MTIME_HI read returns SHADOW_HI. Software reads LO then HI to get a coherent 64-bit value.

Match:
- Each cycle, if MTIME ≥ CMP (unsigned 64-bit, registered values), MATCH is set.
- A write-1-to-clear of MATCH in the same cycle as a true compare leaves MATCH = 1 (set wins).
- Writes to CMP take effect for the compare in the following cycle.

Outputs:
- `irq_o = MATCH & IRQ_EN`, driven from flops only.
- `rdata_o` is loaded on `req_i & ~we_i` with the addressed register and is loaded with 0 on any other cycle.
- No wait states: every request completes in the cycle it is presented.

## Timing
Reset:
- Asserting `rst_ni` low at any time, including mid-count, immediately clears all registers to the reset values above.
- During reset, `rdata_o` = 0 and `irq_o` = 0.

Read latency: request in cycle N, data on `rdata_o` in cycle N+1.

Write latency: a write in cycle N is visible in register state, and in a read issued in cycle N+1 (data at N+2), from cycle N+1.

Match/irq latency:
- If MTIME reaches CMP at edge N, MATCH is set at edge N+1.
- `irq_o` rises in the same cycle as MATCH when IRQ_EN = 1.

Tick period: PRESCALE=P with EN=1 gives one MTIME increment every P+1 cycles. The first tick comes P+1 cycles after EN is set with `pcnt` = 0.

## Structure
- Package `bus_timer_pkg`:
  - register offset localparams;
  - CTRL/STATUS bit indices;
  - reset constants for CMP and the other registers;
  - `timer_reg_e` enum for the decoded offset.
- Sub-module `bus_timer_prescaler`:
  - inputs `en_i`, `prescale_i`, `clear_i`;
  - output `tick_o`;
  - owns `pcnt`.
- The top module holds the register file, read mux, SHADOW_HI and the compare logic.

## Test plan
- Reset: hold `rst_ni` low mid-count with MTIME=0x1234 → all registers return to reset values, `irq_o`=0, CMP reads 0xFFFF_FFFF.
- Prescale: write PRESCALE=3, CTRL=1 → MTIME_LO reads 0x5 after 20 cycles; with PRESCALE=0, MTIME_LO increments every cycle.
- Carry and atomic read: write MTIME_LO=0xFFFF_FFFE, MTIME_HI=0x7, EN=1, PRESCALE=0, then read LO then HI after the wrap → HI=0x8 and coherent with LO; no torn value if LO is read at 0xFFFF_FFFF.
- Compare and irq: CMP=0x0_0000_0010, IRQ_EN=1, EN=1, PRESCALE=0 → MATCH and `irq_o` rise one cycle after MTIME reaches 0x10. W1C of STATUS while MTIME ≥ CMP keeps MATCH=1. Setting CMP=0xFFFF_FFFF_FFFF_FFFF then W1C → `irq_o`=0.
- Write/tick collision: write MTIME_LO=0x100 in a tick cycle → next read returns 0x100, not 0x101; MTIME_HI unchanged.
- Back-to-back bus traffic: alternate write CTRL / read CTRL / read 0x1C on consecutive cycles → reads return the new CTRL value and 0; `rdata_o`=0 on idle cycles.
